// File: rtl/nes_pad_reader_pkg.sv
// nes_pad_reader_pkg: shared FSM encoding and controller button bit positions.
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } state_t;

    // NES order as shifted out of the pad; SNES continues with the extras.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_SNES_A = 8;
    localparam int BTN_SNES_X = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/pad_shift_channel.sv
// pad_shift_channel: per-pad synchroniser, bit capture register and published
// held/pressed vectors.
module pad_shift_channel
    import nes_pad_reader_pkg::*;
#(
    parameter int PAD_BITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data,
    input  logic                sample,
    input  logic                publish,
    input  logic [IDX_W-1:0]    idx,
    output logic [PAD_BITS-1:0] buttons,
    output logic [PAD_BITS-1:0] pressed
);

    logic [1:0]          sync;
    logic [PAD_BITS-1:0] cap;
    logic [PAD_BITS-1:0] next_cap;

    // The final bit is folded in combinationally so buttons update with valid.
    always_comb begin
        next_cap      = cap;
        next_cap[idx] = ~sync[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            cap     <= '0;
            buttons <= '0;
            pressed <= '0;
        end else begin
            sync <= {sync[0], data};
            if (sample)
                cap <= next_cap;
            if (publish) begin
                buttons <= next_cap;
                pressed <= next_cap & ~buttons;
            end
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: reads NUM_PADS serial NES/SNES pads on a shared latch/clock
// after each trigger and publishes held and newly-pressed buttons.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int NUM_PADS = 1,
    parameter int PAD_BITS = 8,
    parameter int CLK_DIV  = 150
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trigger,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*PAD_BITS-1:0] buttons,
    output logic [NUM_PADS*PAD_BITS-1:0] pressed,
    output logic                         valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = PAD_BITS > 1 ? $clog2(PAD_BITS) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             half_end;
    logic             latch_end;
    logic             last_bit;
    logic             sample;
    logic             publish;

    assign half_end  = cnt == CNT_W'(CLK_DIV - 1);
    assign latch_end = cnt == CNT_W'(2 * CLK_DIV - 1);
    assign last_bit  = idx == IDX_W'(PAD_BITS - 1);
    assign sample    = state == SHIFT_HI && half_end;
    assign publish   = sample && last_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
            valid <= 1'b0;
            if (trigger && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (trigger) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: if (latch_end) begin
                    state     <= SHIFT_HI;
                    cnt       <= '0;
                    idx       <= '0;
                    pad_latch <= 1'b0;
                end
                SHIFT_HI: if (half_end) begin
                    cnt <= '0;
                    if (last_bit) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        state   <= SHIFT_LO;
                        pad_clk <= 1'b0;
                    end
                end
                SHIFT_LO: if (half_end) begin
                    state   <= SHIFT_HI;
                    cnt     <= '0;
                    idx     <= idx + 1'b1;
                    pad_clk <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_shift_channel #(
            .PAD_BITS(PAD_BITS),
            .IDX_W   (IDX_W)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .data   (pad_data[p]),
            .sample (sample),
            .publish(publish),
            .idx    (idx),
            .buttons(buttons[p*PAD_BITS +: PAD_BITS]),
            .pressed(pressed[p*PAD_BITS +: PAD_BITS])
        );
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: drives CD4021-style pad models with random buttons and
// checks published vectors and latch/clock waveforms against frame-level expectations.
module tb_nes_pad_reader;
    import nes_pad_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [1:0]  pad_data;
    logic        pad_latch, pad_clk, valid, busy, overrun;
    logic [15:0] buttons, pressed;
    logic        pad_data2;
    logic        pad_latch2, pad_clk2, valid2, busy2, overrun2;
    logic [15:0] buttons2, pressed2;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  btn0 = '0, btn1 = '0, sr0 = '1, sr1 = '1;
    logic [15:0] btn16 = '0, sr16 = '1;
    logic [1:0]  disc = '0;
    logic [15:0] prev = '0, prev16 = '0;

    always #5 clk = ~clk;

    nes_pad_reader #(.NUM_PADS(2), .PAD_BITS(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .pressed(pressed), .valid(valid), .busy(busy), .overrun(overrun)
    );

    nes_pad_reader #(.NUM_PADS(1), .PAD_BITS(16), .CLK_DIV(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .pad_data(pad_data2),
        .pad_latch(pad_latch2), .pad_clk(pad_clk2), .buttons(buttons2),
        .pressed(pressed2), .valid(valid2), .busy(busy2), .overrun(overrun2)
    );

    // Pads: parallel load while latched, shift toward the output on pad_clk rise.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            sr0 <= ~btn0;
            sr1 <= ~btn1;
        end else begin
            sr0 <= {1'b1, sr0[7:1]};
            sr1 <= {1'b1, sr1[7:1]};
        end
    end

    always @(posedge pad_latch2 or posedge pad_clk2) begin
        if (pad_latch2) sr16 <= ~btn16;
        else            sr16 <= {1'b1, sr16[15:1]};
    end

    assign pad_data[0] = disc[0] | sr0[0];
    assign pad_data[1] = disc[1] | sr1[0];
    assign pad_data2   = sr16[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] d,
                         input logic [15:0] b16, input int retrig);
        int first_valid = -1, n_valid = 0, first_v2 = -1, n_v2 = 0;
        int latch_bad = 0, falls = 0, low_cycles = 0, bad_len = 0, run = 0;
        logic prev_clk = 1'b1, busy1 = 1'b0, busy70 = 1'b1;
        logic [15:0] exp, expp, got_b = '0, got_p = '0, got_b16 = '0, got_p16 = '0;
        btn0 = b0; btn1 = b1; disc = d; btn16 = b16;
        exp  = {d[1] ? 8'h00 : b1, d[0] ? 8'h00 : b0};
        expp = exp & ~prev;
        @(negedge clk) trigger = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            trigger = (k == retrig);
            if (valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
                got_b = buttons; got_p = pressed;
            end
            if (valid2) begin
                n_v2++;
                if (first_v2 < 0) first_v2 = k;
                got_b16 = buttons2; got_p16 = pressed2;
            end
            if (pad_latch != (k >= 1 && k <= 8)) latch_bad++;
            if (!pad_clk) begin
                low_cycles++; run++;
                if (prev_clk) falls++;
            end else if (!prev_clk) begin
                if (run != 4) bad_len++;
                run = 0;
            end
            prev_clk = pad_clk;
            if (k == 1)  busy1 = busy;
            if (k == 70) busy70 = busy;
        end
        check("valid_cycle", first_valid, 69);
        check("valid_count", n_valid, 1);
        check("buttons", 32'(got_b), 32'(exp));
        check("pressed", 32'(got_p), 32'(expp));
        check("latch_window", latch_bad, 0);
        check("clk_low_pulses", falls, 7);
        check("clk_low_cycles", low_cycles, 28);
        check("clk_pulse_len", bad_len, 0);
        check("clk_idle_high", 32'(pad_clk), 1);
        check("busy_start", 32'(busy1), 1);
        check("busy_end", 32'(busy70), 0);
        check("valid16_cycle", first_v2, 133);
        check("valid16_count", n_v2, 1);
        check("buttons16", 32'(got_b16), 32'(b16));
        check("pressed16", 32'(got_p16), 32'(b16 & ~prev16));
        prev   = exp;
        prev16 = b16;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_latch"},   32'(pad_latch), 0);
        check({tag, "_clk"},     32'(pad_clk),   1);
        check({tag, "_buttons"}, 32'(buttons),   0);
        check({tag, "_pressed"}, 32'(pressed),   0);
        check({tag, "_valid"},   32'(valid),     0);
        check({tag, "_busy"},    32'(busy),      0);
        check({tag, "_overrun"}, 32'(overrun),   0);
    endtask

    initial begin
        int stray = 0;
        logic [7:0] a_right, a_, up_right;
        a_right  = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
        up_right = 8'((1 << BTN_UP) | (1 << BTN_RIGHT));
        a_       = 8'(1 << BTN_A);
        repeat (3) @(negedge clk);
        check_reset_state("init");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(a_right, 8'h00, 2'b00, 16'h0A55, 0);
        frame(a_right, 8'h00, 2'b00, 16'h0A55, 0);
        frame(up_right, 8'h00, 2'b00, 16'h5A0A, 0);

        frame(8'($urandom), 8'($urandom), 2'b00, 16'($urandom), 20);
        check("overrun_set", 32'(overrun), 1);
        frame(8'($urandom), 8'($urandom), 2'b00, 16'($urandom), 69);
        check("overrun_sticky", 32'(overrun), 1);

        frame(a_, 8'($urandom), 2'b10, 16'($urandom), 0);
        for (int i = 0; i < 4; i++)
            frame(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 0);

        btn0 = 8'($urandom); btn1 = 8'($urandom); btn16 = 16'($urandom);
        @(negedge clk) trigger = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            if (k == 34) rst_n = 1'b0;
        end
        @(negedge clk);
        check_reset_state("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (valid || valid2) stray++;
        end
        check("no_partial_valid", stray, 0);
        prev = '0; prev16 = '0;
        frame(8'($urandom), 8'($urandom), 2'b00, 16'($urandom), 0);
        check("overrun_after_reset", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
